// File: rtl/window_addr_seq.sv
// Round-robin column address sequencer: sweeps NCOL address channels one slot per cycle,
// wrapping each at a latched limit, and signals completion when the last channel wraps.
module window_addr_seq #(
    parameter int NCOL = 4,
    parameter int AW   = 8,
    localparam int SW  = (NCOL > 1) ? $clog2(NCOL) : 1
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Start,
    input  logic               FirstCmp,
    input  logic [AW-1:0]      LastAddr,
    input  logic               Stall,
    output logic [NCOL*AW-1:0] Addr,
    output logic [SW-1:0]      Sel,
    output logic               Valid,
    output logic               Busy,
    output logic               Done,
    output logic [1:0]         DbgState
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   addr_q [NCOL];
    logic [SW-1:0]   slot_q;
    logic [AW-1:0]   last_q;
    logic            fc_q;
    logic            first_q;
    logic            advance;
    logic            pair_mode;
    logic [NCOL-1:0] inc_en;
    logic            wrap_last;

    // Handshake: Valid is high exactly in the cycles where the serviced slot advances
    // (RUN and Stall low); there is no backpressure beyond Stall.
    assign advance   = (state == RUN) && !Stall;
    assign pair_mode = fc_q && first_q;

    // In the first round of first-comparison mode, channel 0's step moves from slot 0 to slot 1.
    always_comb begin
        inc_en = '0;
        for (int c = 0; c < NCOL; c++) begin
            if (advance) begin
                if (slot_q == SW'(c) && !(pair_mode && c == 0))
                    inc_en[c] = 1'b1;
                if (pair_mode && c == 0 && slot_q == SW'(1))
                    inc_en[c] = 1'b1;
            end
        end
    end

    assign wrap_last = inc_en[NCOL-1] && (addr_q[NCOL-1] == last_q);

    always_ff @(posedge Clk) begin
        if (Rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Start) state_nxt = RUN;
            RUN:     if (wrap_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        Valid    = advance;
        Busy     = (state == RUN);
        Done     = (state == DONE);
        DbgState = state;
        Sel      = slot_q;
        Addr     = '0;
        for (int c = 0; c < NCOL; c++)
            Addr[c*AW +: AW] = addr_q[c];
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int c = 0; c < NCOL; c++)
                addr_q[c] <= '0;
            slot_q  <= '0;
            last_q  <= '0;
            fc_q    <= 1'b0;
            first_q <= 1'b0;
        end else if (state == IDLE && Start) begin
            for (int c = 0; c < NCOL; c++)
                addr_q[c] <= '0;
            slot_q  <= '0;
            last_q  <= LastAddr;
            fc_q    <= FirstCmp;
            first_q <= 1'b1;
        end else if (advance) begin
            for (int c = 0; c < NCOL; c++) begin
                if (inc_en[c])
                    addr_q[c] <= (addr_q[c] == last_q) ? '0 : addr_q[c] + AW'(1);
            end
            if (slot_q == SW'(NCOL-1)) begin
                slot_q  <= '0;
                first_q <= 1'b0;
            end else begin
                slot_q <= slot_q + SW'(1);
            end
        end
    end

endmodule

// File: tb/tb_window_addr_seq.sv
// Directed bench for window_addr_seq (NCOL=4, AW=8): full sweeps, first-comparison mode,
// mid-sweep stall, zero limit, reset abort and ignored Start pulses.
module tb_window_addr_seq;

    localparam int NCOL = 4;
    localparam int AW   = 8;
    localparam int SW   = 2;

    logic               clk;
    logic               rst;
    logic               start;
    logic               first_cmp;
    logic [AW-1:0]      last_addr;
    logic               stall;
    logic [NCOL*AW-1:0] addr;
    logic [SW-1:0]      sel;
    logic               valid;
    logic               busy;
    logic               done;
    logic [1:0]         dbg_state;

    int n_vec  = 0;
    int n_fail = 0;

    window_addr_seq #(.NCOL(NCOL), .AW(AW)) dut (
        .Clk      (clk),
        .Rst      (rst),
        .Start    (start),
        .FirstCmp (first_cmp),
        .LastAddr (last_addr),
        .Stall    (stall),
        .Addr     (addr),
        .Sel      (sel),
        .Valid    (valid),
        .Busy     (busy),
        .Done     (done),
        .DbgState (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hand-derived address pattern after k non-stalled RUN cycles: channel c has been
    // serviced once per round starting at k=c+1; first-comparison mode only delays ch0 at k=1.
    function automatic logic [31:0] exp_addr(input bit fc, input int last, input int k);
        logic [31:0] r;
        int inc;
        r = '0;
        for (int c = 0; c < NCOL; c++) begin
            inc = (k > c) ? ((k - c - 1) / NCOL + 1) : 0;
            if (fc && k == 1 && c == 0) inc = 0;
            r[c*AW +: AW] = 8'(inc % (last + 1));
        end
        return r;
    endfunction

    task automatic run_sweep(input string tag, input bit fc, input int last,
                             input int stall_k, input int stall_n, input bit poke);
        int k;
        int stalls;
        int n_total;
        bit stall_now;
        n_total   = NCOL * (last + 1);
        first_cmp = fc;
        last_addr = 8'(last);
        start     = 1'b1;
        step();
        start     = 1'b0;
        first_cmp = 1'b0;
        last_addr = 8'hA5;
        k      = 0;
        stalls = 0;
        while (k < n_total) begin
            stall_now = (k == stall_k) && (stalls < stall_n);
            stall     = stall_now;
            start     = poke && (k == 3) && !stall_now;
            #1;
            check({tag, " busy"},  32'(busy),  32'd1);
            check({tag, " done"},  32'(done),  32'd0);
            check({tag, " valid"}, 32'(valid), 32'(!stall_now));
            check({tag, " sel"},   32'(sel),   32'(k % NCOL));
            check({tag, " addr"},  addr,       exp_addr(fc, last, k));
            if (stall_now) stalls++;
            else k++;
            step();
        end
        stall = 1'b0;
        start = poke;
        #1;
        check({tag, " done_pulse"}, 32'(done),  32'd1);
        check({tag, " done_busy"},  32'(busy),  32'd0);
        check({tag, " done_valid"}, 32'(valid), 32'd0);
        check({tag, " end_addr"},   addr,       exp_addr(fc, last, n_total));
        step();
        start = 1'b0;
        check({tag, " idle_done"}, 32'(done), 32'd0);
        check({tag, " idle_busy"}, 32'(busy), 32'd0);
        step();
        check({tag, " idle2_busy"}, 32'(busy), 32'd0);
        check({tag, " idle2_done"}, 32'(done), 32'd0);
        check({tag, " idle2_addr"}, addr,      32'h0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        first_cmp = 1'b0;
        last_addr = '0;
        stall     = 1'b0;
        step();
        step();
        check("rst addr",  addr,            32'h0);
        check("rst sel",   32'(sel),        32'd0);
        check("rst valid", 32'(valid),      32'd0);
        check("rst busy",  32'(busy),       32'd0);
        check("rst done",  32'(done),       32'd0);
        check("rst state", 32'(dbg_state),  32'd0);
        rst = 1'b0;
        step();
        check("idle busy", 32'(busy), 32'd0);

        run_sweep("basic",   1'b0, 3, -1, 0, 1'b0);
        run_sweep("first",   1'b1, 3, -1, 0, 1'b0);
        run_sweep("stall",   1'b0, 3,  6, 3, 1'b0);
        run_sweep("zero",    1'b0, 0, -1, 0, 1'b0);
        run_sweep("ignore",  1'b0, 3, -1, 0, 1'b1);
        run_sweep("first_z", 1'b1, 0, -1, 0, 1'b0);

        // Abort a sweep with Rst while Start is also high.
        last_addr = 8'd3;
        start     = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("abort addr0", 32'(addr[7:0]), 32'd2);
        check("abort busy",  32'(busy),       32'd1);
        rst   = 1'b1;
        start = 1'b1;
        step();
        check("abort rst addr",  addr,           32'h0);
        check("abort rst sel",   32'(sel),       32'd0);
        check("abort rst valid", 32'(valid),     32'd0);
        check("abort rst busy",  32'(busy),      32'd0);
        check("abort rst done",  32'(done),      32'd0);
        check("abort rst state", 32'(dbg_state), 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        step();
        check("post rst busy", 32'(busy), 32'd0);
        run_sweep("fresh", 1'b0, 3, -1, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
